// File: rtl/wb_write_scheduler_pkg.sv
// Shared types for the writeback scheduler: register address width and queue entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_write_scheduler_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_REG_W  = 5;

  typedef logic [WB_REG_W-1:0] reg_addr_t;

  // One pending register-file write, at the default data width.
  typedef struct packed {
    reg_addr_t              dest;
    logic [WB_DATA_W-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_write_scheduler_if.sv
// Bundle of the two writeback request slots, the lookup probe and the register-file write port.
// Latency: n/a (wires only).
// Backpressure: stall_o is driven by the scheduler towards the writeback stage.
interface wb_write_scheduler_if
  import wb_write_scheduler_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W
);

  logic              wb0_valid;
  reg_addr_t         wb0_dest;
  logic [DATA_W-1:0] wb0_data;
  logic              wb1_valid;
  reg_addr_t         wb1_dest;
  logic [DATA_W-1:0] wb1_data;
  reg_addr_t         lookup_reg;

  logic              rf_we;
  reg_addr_t         rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              stall_o;
  logic              pending_hit;
  logic              overflow_err;

  // Writeback / issue side: presents requests, watches stall and results.
  modport master (
    output wb0_valid, wb0_dest, wb0_data,
    output wb1_valid, wb1_dest, wb1_data,
    output lookup_reg,
    input  rf_we, rf_waddr, rf_wdata, stall_o, pending_hit, overflow_err
  );

  // Scheduler side.
  modport slave (
    input  wb0_valid, wb0_dest, wb0_data,
    input  wb1_valid, wb1_dest, wb1_data,
    input  lookup_reg,
    output rf_we, rf_waddr, rf_wdata, stall_o, pending_hit, overflow_err
  );

endinterface

// File: rtl/wb_pend_fifo.sv
// Circular queue of pending register writes, up to two pushes and one pop per cycle, plus dest match vector.
// Latency: a pushed entry is visible at the head the cycle after the push edge when the queue was empty.
// Backpressure: none inside; the caller must never push more than the free space after its own pop.
module wb_pend_fifo
  import wb_write_scheduler_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = WB_DATA_W,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        push_cnt_i,
  input  reg_addr_t         push0_dest_i,
  input  logic [DATA_W-1:0] push0_data_i,
  input  reg_addr_t         push1_dest_i,
  input  logic [DATA_W-1:0] push1_data_i,
  input  logic              pop_i,
  input  reg_addr_t         lookup_i,
  output logic [CW-1:0]     count_o,
  output reg_addr_t         head_dest_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [DEPTH-1:0]  match_o
);

  reg_addr_t         dest_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wr_ptr_nxt1;

  // Pointer and occupancy update; pointers wrap naturally at PW bits.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + PW'(push_cnt_i);
    rd_ptr_d    = rd_ptr_q + PW'(pop_i);
    count_d     = count_q + CW'(push_cnt_i) - CW'(pop_i);
    wr_ptr_nxt1 = wr_ptr_q + PW'(1);
  end

  // Storage and pointer registers; reset clears every entry as well.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_cnt_i != 2'd0) begin
        dest_q[wr_ptr_q] <= push0_dest_i;
        data_q[wr_ptr_q] <= push0_data_i;
      end
      if (push_cnt_i == 2'd2) begin
        dest_q[wr_ptr_nxt1] <= push1_dest_i;
        data_q[wr_ptr_nxt1] <= push1_data_i;
      end
    end
  end

  // Head is forced to zero when empty so the write port idles cleanly.
  always_comb begin
    head_dest_o = '0;
    head_data_o = '0;
    if (count_q != '0) begin
      head_dest_o = dest_q[rd_ptr_q];
      head_data_o = data_q[rd_ptr_q];
    end
  end

  // Per-entry match; an entry is occupied when its distance from the head is below count.
  always_comb begin
    logic [PW-1:0] off;
    off     = '0;
    match_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off        = PW'(i) - rd_ptr_q;
      match_o[i] = ({1'b0, off} < count_q) && (dest_q[i] == lookup_i);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/wb_write_scheduler.sv
// Funnels two writeback slots into one register-file write port through a small pending-write queue.
// Latency: a request accepted at edge N drives the write port in cycle N+1 when the queue was empty.
// Backpressure: stall_o when fewer than two entries are free; excess requests are dropped inst1-first and flagged.
module wb_write_scheduler
  import wb_write_scheduler_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WB_DATA_W
) (
  input  logic                 clk,
  input  logic                 reset,
  wb_write_scheduler_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]     count;
  logic [CW-1:0]     free_after_pop;
  logic              pop;
  logic              v0, v1, acc0, acc1, drop;
  logic [1:0]        push_cnt;
  reg_addr_t         p0_dest;
  logic [DATA_W-1:0] p0_data;
  reg_addr_t         head_dest;
  logic [DATA_W-1:0] head_data;
  logic [DEPTH-1:0]  match;
  logic              overflow_q, overflow_d;

  wb_pend_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_cnt_i   (push_cnt),
    .push0_dest_i (p0_dest),
    .push0_data_i (p0_data),
    .push1_dest_i (bus.wb1_dest),
    .push1_data_i (bus.wb1_data),
    .pop_i        (pop),
    .lookup_i     (bus.lookup_reg),
    .count_o      (count),
    .head_dest_o  (head_dest),
    .head_data_o  (head_data),
    .match_o      (match)
  );

  // The head drains every cycle the queue is non-empty.
  assign pop            = (count != '0);
  assign free_after_pop = CW'(DEPTH) - count + CW'(pop);

  // Request filtering, younger-wins collision, space check, and compaction into push slots.
  always_comb begin
    v0 = bus.wb0_valid && (bus.wb0_dest != '0);
    v1 = bus.wb1_valid && (bus.wb1_dest != '0);
    if (v0 && v1 && (bus.wb0_dest == bus.wb1_dest)) begin
      v0 = 1'b0;
    end
    acc0     = v0 && (free_after_pop != '0);
    acc1     = v1 && (free_after_pop >= (acc0 ? CW'(2) : CW'(1)));
    drop     = (v0 && !acc0) || (v1 && !acc1);
    push_cnt = {1'b0, acc0} + {1'b0, acc1};
    p0_dest  = acc0 ? bus.wb0_dest : bus.wb1_dest;
    p0_data  = acc0 ? bus.wb0_data : bus.wb1_data;
  end

  // Sticky overflow flag, cleared only by reset.
  always_comb begin
    overflow_d = overflow_q | drop;
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign bus.rf_we        = pop;
  assign bus.rf_waddr     = head_dest;
  assign bus.rf_wdata     = head_data;
  assign bus.stall_o      = (count > CW'(DEPTH - 2));
  assign bus.pending_hit  = (bus.lookup_reg != '0) && (|match);
  assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_wb_write_scheduler.sv
// Directed bench for the writeback scheduler with hand-computed expectations.
// Latency: inputs change 1 time unit after the rising edge, outputs are checked 1 unit later.
// Backpressure: stall and drop behaviour exercised with a DEPTH=4 queue.
module tb_wb_write_scheduler;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  wb_write_scheduler_if #(.DATA_W(32)) bus ();

  wb_write_scheduler #(
    .DEPTH  (4),
    .DATA_W (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [4:0] d0, input logic [31:0] x0,
                       input logic v1, input logic [4:0] d1, input logic [31:0] x1);
    bus.wb0_valid = v0;
    bus.wb0_dest  = d0;
    bus.wb0_data  = x0;
    bus.wb1_valid = v1;
    bus.wb1_dest  = d1;
    bus.wb1_data  = x1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    bus.lookup_reg = 5'd0;
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 64'(bus.rf_we), 64'd1);
    chk({tag, "_addr"}, 64'(bus.rf_waddr), 64'(a));
    chk({tag, "_data"}, 64'(bus.rf_wdata), 64'(d));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_we", 64'(bus.rf_we), 64'd0);
    chk("rst_addr", 64'(bus.rf_waddr), 64'd0);
    chk("rst_data", 64'(bus.rf_wdata), 64'd0);
    chk("rst_stall", 64'(bus.stall_o), 64'd0);
    chk("rst_hit", 64'(bus.pending_hit), 64'd0);
    chk("rst_ovf", 64'(bus.overflow_err), 64'd0);

    // Single request, one-cycle latency, then empty again.
    step();
    drive(1'b1, 5'd3, 32'hA, 1'b0, 5'd0, 32'h0);
    #1;
    chk("t1_pre_we", 64'(bus.rf_we), 64'd0);
    step();
    idle();
    #1;
    chk_wr("t1", 5'd3, 32'hA);
    step();
    #1;
    chk("t1_empty_we", 64'(bus.rf_we), 64'd0);

    // Pair in program order.
    drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22);
    step();
    idle();
    #1;
    chk_wr("t2a", 5'd5, 32'h11);
    step();
    #1;
    chk_wr("t2b", 5'd6, 32'h22);
    step();
    #1;
    chk("t2_empty_we", 64'(bus.rf_we), 64'd0);

    // Same-dest collision keeps only the younger write; dest 0 is ignored.
    drive(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
    step();
    idle();
    #1;
    chk_wr("t3", 5'd7, 32'h2);
    step();
    #1;
    chk("t3_single_we", 64'(bus.rf_we), 64'd0);
    drive(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0);
    step();
    idle();
    #1;
    chk("t3_dest0_we", 64'(bus.rf_we), 64'd0);

    // Back-to-back pairs fill the queue; stall and pending lookup.
    drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h102);
    step();
    drive(1'b1, 5'd3, 32'h103, 1'b1, 5'd4, 32'h104);
    #1;
    chk("t4_stall_cnt2", 64'(bus.stall_o), 64'd0);
    chk("t4_head1", 64'(bus.rf_waddr), 64'd1);
    step();
    idle();
    bus.lookup_reg = 5'd3;
    #1;
    chk("t4_stall_cnt3", 64'(bus.stall_o), 64'd1);
    chk("t4_hit3", 64'(bus.pending_hit), 64'd1);
    chk("t4_head2", 64'(bus.rf_waddr), 64'd2);
    bus.lookup_reg = 5'd1;
    #1;
    chk("t4_hit_popped", 64'(bus.pending_hit), 64'd0);
    bus.lookup_reg = 5'd0;
    #1;
    chk("t4_hit_zero", 64'(bus.pending_hit), 64'd0);
    drive(1'b1, 5'd8, 32'h108, 1'b1, 5'd9, 32'h109);
    #1;
    chk("t4_ovf_none", 64'(bus.overflow_err), 64'd0);
    step();
    drive(1'b1, 5'd10, 32'h10A, 1'b1, 5'd11, 32'h10B);
    #1;
    chk("t5_full_stall", 64'(bus.stall_o), 64'd1);
    chk("t5_head3", 64'(bus.rf_waddr), 64'd3);
    step();
    idle();
    #1;
    chk("t5_ovf_set", 64'(bus.overflow_err), 64'd1);
    chk_wr("t5_d4", 5'd4, 32'h104);
    step();
    #1;
    chk_wr("t5_d8", 5'd8, 32'h108);
    step();
    #1;
    chk_wr("t5_d9", 5'd9, 32'h109);
    step();
    #1;
    chk_wr("t5_d10", 5'd10, 32'h10A);
    step();
    #1;
    chk("t5_drained_we", 64'(bus.rf_we), 64'd0);
    chk("t5_ovf_sticky", 64'(bus.overflow_err), 64'd1);
    chk("t5_stall_clr", 64'(bus.stall_o), 64'd0);

    // Reset with three entries queued discards them.
    drive(1'b1, 5'd12, 32'h10C, 1'b1, 5'd13, 32'h10D);
    step();
    drive(1'b1, 5'd14, 32'h10E, 1'b1, 5'd15, 32'h10F);
    step();
    idle();
    #1;
    chk("t6_stall_cnt3", 64'(bus.stall_o), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("t6_we", 64'(bus.rf_we), 64'd0);
    chk("t6_addr", 64'(bus.rf_waddr), 64'd0);
    chk("t6_stall", 64'(bus.stall_o), 64'd0);
    chk("t6_ovf", 64'(bus.overflow_err), 64'd0);
    chk("t6_count", 64'(dut.count), 64'd0);
    bus.lookup_reg = 5'd14;
    #1;
    chk("t6_hit", 64'(bus.pending_hit), 64'd0);
    step();
    #1;
    chk("t6_we_later", 64'(bus.rf_we), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
